round_robin_arbiter: RTL and testbench
======================================

// Module: round_robin_arbiter
// PURPOSE
//  Shares one resource (memory port, bus master slot) among NUM_REQ requesters.
//  Grants are round-robin fair: after a tenure ends, the requester above the last
//  winner has top priority. A grant is held until the resource reports done or a
//  watchdog timeout expires. Sits between core/cache request lines and the resource.
// PARAMETERS
//  NUM_REQ  4   number of requesters, >=2, any value (power of 2 not required)
//  TIMEOUT  0   max BUSY cycles per tenure; 0 disables the watchdog
// PORTS
//  clock        in   1                  system clock, rising edge
//  reset        in   1                  asynchronous, active-high
//  request      in   NUM_REQ            per-requester request level
//  done         in   1                  resource: current tenure complete (1-cycle pulse)
//  grant        out  NUM_REQ            one-hot grant, registered
//  grant_index  out  log2(NUM_REQ)      binary index of granted requester
//  grant_valid  out  1                  =|grant
//  timeout      out  1                  1-cycle pulse: tenure forcibly ended by watchdog
// BEHAVIOUR
//  Reset (async): state=IDLE, grant=0, grant_index=0, grant_valid=0, timeout=0,
//   last_winner=NUM_REQ-1 (requester 0 wins first), watchdog count=0.
//  States: IDLE, BUSY. All outputs are registered.
//  IDLE: if |request, pick winner; next edge: grant=onehot(winner),
//   grant_index=winner, grant_valid=1, count=0, state=BUSY. Else stay IDLE.
//   Request->grant latency: 1 cycle.
//  Winner selection: masked = request & bits strictly above last_winner;
//   winner = lowest set bit of masked if |masked, else lowest set bit of request.
//  BUSY: grant/grant_index held stable regardless of request changes
//   (requester deasserting request does NOT end tenure).
//   done=1 -> next edge: grant=0, grant_valid=0, last_winner=grant_index, state=IDLE.
//   TIMEOUT>0 and count==TIMEOUT-1 and done=0 -> next edge: same release as done,
//    plus timeout=1 for exactly one cycle. Otherwise count increments.
//   done and watchdog expiry in same cycle: done wins, timeout stays 0.
//  Minimum one IDLE cycle between tenures; back-to-back grant spacing >= 1 cycle
//   of grant_valid=0.
//  done while IDLE: ignored. grant_index holds last value while IDLE.
//  Count width log2(TIMEOUT+1), min 1; never wraps (cleared on entry to BUSY).
//  Reset asserted mid-BUSY: grant drops immediately (async), pointer returns to reset.
// STRUCTURE
//  Shared `include header: log2() function, state encodings IDLE/BUSY.
//  Two priority_encoder instances (PRIORITY="LSB", WIDTH=NUM_REQ): one on masked
//   requests, one on raw requests; masked valid selects which index wins.
//  Mask generation, FSM, watchdog counter and output registers in this module.
// TESTING
//  1. NUM_REQ=4, request=4'b1111 held, done pulsed 2 cycles after each grant
//     -> grant_index sequence 0,1,2,3,0; one grant_valid=0 cycle between tenures.
//  2. last_winner=2, request=4'b0011 -> grant_index=0 (wrap-around); then
//     request=4'b1001, last_winner=0 -> grant_index=3.
//  3. Grant to 1, deassert request[1] while BUSY -> grant stays 4'b0010 until done.
//  4. TIMEOUT=5, grant with no done -> grant drops after 5 BUSY cycles, timeout=1
//     for one cycle, next grant goes to the next requester above.
//  5. TIMEOUT=5, done on the 5th BUSY cycle -> release, timeout remains 0.
//  6. NUM_REQ=3, reset asserted mid-BUSY -> grant=0 same cycle; after release,
//     request=3'b111 -> grant_index=0. Also done pulsed in IDLE -> no state change.

Source files
------------

// File: rtl/round_robin_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encoding and
// a ceiling-log2 helper used for index and counter widths.
package round_robin_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Ceiling log2 with a floor of 1 bit, so single-value ranges still get a wire.
  function automatic int unsigned log2(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((w < 32) && ((32'd1 << w) < value)) w++;
    return w;
  endfunction

endpackage

// File: rtl/round_robin_arbiter_priority_encoder.sv
// Priority encoder: binary index of the lowest ("LSB") or highest ("MSB")
// set bit, plus a valid flag when any bit is set.
module round_robin_arbiter_priority_encoder
  import round_robin_arbiter_pkg::*;
#(
  parameter string       PRIORITY = "LSB",
  parameter int unsigned WIDTH    = 4
) (
  input  logic [WIDTH-1:0]        req,
  output logic [log2(WIDTH)-1:0]  index,
  output logic                    valid
);

  localparam int unsigned IW = log2(WIDTH);

  always_comb begin
    logic found;
    index = '0;
    found = 1'b0;
    valid = |req;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (PRIORITY == "MSB") begin
        if (req[i]) index = i[IW-1:0];
      end else if (req[i] && !found) begin
        index = i[IW-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: one-hot registered grant held until done or watchdog
// expiry; priority rotates to the requester above the last winner.
module round_robin_arbiter
  import round_robin_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         request,
  input  logic                       done,
  output logic [NUM_REQ-1:0]         grant,
  output logic [log2(NUM_REQ)-1:0]   grant_index,
  output logic                       grant_valid,
  output logic                       timeout
);

  localparam int unsigned IDX_W = log2(NUM_REQ);
  localparam int unsigned CNT_W = log2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  arb_state_e         state, state_n;
  logic [IDX_W-1:0]   last_winner, last_winner_n;
  logic [CNT_W-1:0]   count, count_n;
  logic [NUM_REQ-1:0] grant_n;
  logic [IDX_W-1:0]   grant_index_n;
  logic               grant_valid_n, timeout_n;

  logic [NUM_REQ-1:0] above_mask, masked;
  logic [IDX_W-1:0]   m_idx, r_idx, winner;
  logic               m_valid, r_valid, expire;

  always_comb begin
    above_mask = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      above_mask[i] = (i > 32'(last_winner));
  end

  assign masked = request & above_mask;

  round_robin_arbiter_priority_encoder #(.PRIORITY("LSB"), .WIDTH(NUM_REQ)) u_pe_masked (
    .req   (masked),
    .index (m_idx),
    .valid (m_valid)
  );

  round_robin_arbiter_priority_encoder #(.PRIORITY("LSB"), .WIDTH(NUM_REQ)) u_pe_raw (
    .req   (request),
    .index (r_idx),
    .valid (r_valid)
  );

  assign winner = m_valid ? m_idx : r_idx;
  assign expire = (TIMEOUT != 0) && (count == CNT_LAST);

  always_comb begin
    state_n       = state;
    last_winner_n = last_winner;
    count_n       = count;
    grant_n       = grant;
    grant_index_n = grant_index;
    grant_valid_n = grant_valid;
    timeout_n     = 1'b0;
    unique case (state)
      IDLE: begin
        if (r_valid) begin
          state_n         = BUSY;
          grant_n         = '0;
          grant_n[winner] = 1'b1;
          grant_index_n   = winner;
          grant_valid_n   = 1'b1;
          count_n         = '0;
        end
      end
      BUSY: begin
        // done takes precedence, so a same-cycle expiry never raises timeout
        if (done || expire) begin
          state_n       = IDLE;
          grant_n       = '0;
          grant_valid_n = 1'b0;
          last_winner_n = grant_index;
          timeout_n     = !done;
        end else if (TIMEOUT != 0) begin
          count_n = count + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_winner <= IDX_W'(NUM_REQ - 1);
      count       <= '0;
      grant       <= '0;
      grant_index <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_n;
      last_winner <= last_winner_n;
      count       <= count_n;
      grant       <= grant_n;
      grant_index <= grant_index_n;
      grant_valid <= grant_valid_n;
      timeout     <= timeout_n;
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed bench for round_robin_arbiter: a vector table for rotation and hold
// behaviour, plus sequences for the watchdog and asynchronous reset.
module tb_round_robin_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // dut_a: NUM_REQ=4, no watchdog
  logic       a_rst, a_done, a_valid, a_tmo;
  logic [3:0] a_req, a_grant;
  logic [1:0] a_idx;
  // dut_b: NUM_REQ=4, TIMEOUT=5
  logic       b_rst, b_done, b_valid, b_tmo;
  logic [3:0] b_req, b_grant;
  logic [1:0] b_idx;
  // dut_c: NUM_REQ=3, no watchdog
  logic       c_rst, c_done, c_valid, c_tmo;
  logic [2:0] c_req, c_grant;
  logic [1:0] c_idx;

  round_robin_arbiter #(.NUM_REQ(4), .TIMEOUT(0)) dut_a (
    .clock(clock), .reset(a_rst), .request(a_req), .done(a_done),
    .grant(a_grant), .grant_index(a_idx), .grant_valid(a_valid), .timeout(a_tmo)
  );
  round_robin_arbiter #(.NUM_REQ(4), .TIMEOUT(5)) dut_b (
    .clock(clock), .reset(b_rst), .request(b_req), .done(b_done),
    .grant(b_grant), .grant_index(b_idx), .grant_valid(b_valid), .timeout(b_tmo)
  );
  round_robin_arbiter #(.NUM_REQ(3), .TIMEOUT(0)) dut_c (
    .clock(clock), .reset(c_rst), .request(c_req), .done(c_done),
    .grant(c_grant), .grant_index(c_idx), .grant_valid(c_valid), .timeout(c_tmo)
  );

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] idx;
    logic       valid;
    logic       tmo;
  } vec_t;

  vec_t vecs[26];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // {req, done} applied before an edge; {grant, idx, valid, tmo} expected after it
    vecs[0]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[1]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[3]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[4]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[5]  = '{4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
    vecs[6]  = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[7]  = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[8]  = '{4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[9]  = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[10] = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[11] = '{4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0};
    vecs[12] = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[13] = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[14] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[15] = '{4'b0011, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[16] = '{4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[17] = '{4'b1001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[18] = '{4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[19] = '{4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0};
    vecs[20] = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[21] = '{4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[22] = '{4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[23] = '{4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
    vecs[24] = '{4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
    vecs[25] = '{4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0};

    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_req = '0; b_req = '0; c_req = '0;
    a_done = 1'b0; b_done = 1'b0; c_done = 1'b0;
    #12;
    check("reset_a", {a_grant, a_idx, a_valid, a_tmo}, '0);
    check("reset_b", {b_grant, b_idx, b_valid, b_tmo}, '0);
    check("reset_c", {c_grant, c_idx, c_valid, c_tmo}, '0);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

    for (int i = 0; i < 26; i++) begin
      a_req  = vecs[i].req;
      a_done = vecs[i].done;
      step();
      check($sformatf("table_row%0d", i), {a_grant, a_idx, a_valid, a_tmo},
            {vecs[i].grant, vecs[i].idx, vecs[i].valid, vecs[i].tmo});
    end

    // Watchdog expiry after 5 BUSY cycles, then rotation to the next requester
    b_req = 4'b0011;
    step();
    check("wd_grant0", {b_grant, b_idx, b_valid, b_tmo}, {4'b0001, 2'd0, 1'b1, 1'b0});
    for (int i = 0; i < 4; i++) step();
    check("wd_hold5", {b_grant, b_idx, b_valid, b_tmo}, {4'b0001, 2'd0, 1'b1, 1'b0});
    step();
    check("wd_expire", {b_grant, b_idx, b_valid, b_tmo}, {4'b0000, 2'd0, 1'b0, 1'b1});
    step();
    check("wd_next", {b_grant, b_idx, b_valid, b_tmo}, {4'b0010, 2'd1, 1'b1, 1'b0});
    // done on the 5th BUSY cycle beats the watchdog
    for (int i = 0; i < 4; i++) step();
    check("wd_hold_b", {b_grant, b_idx, b_valid, b_tmo}, {4'b0010, 2'd1, 1'b1, 1'b0});
    b_done = 1'b1;
    step();
    check("wd_done_wins", {b_grant, b_idx, b_valid, b_tmo}, {4'b0000, 2'd1, 1'b0, 1'b0});
    b_done = 1'b0;
    b_req  = 4'b0000;
    step();
    check("wd_no_pulse", {b_grant, b_idx, b_valid, b_tmo}, {4'b0000, 2'd1, 1'b0, 1'b0});

    // Asynchronous reset mid-BUSY on a 3-requester arbiter
    c_req = 3'b010;
    step();
    check("c_grant1", {c_grant, c_idx, c_valid, c_tmo}, {3'b010, 2'd1, 1'b1, 1'b0});
    step();
    #3;
    c_rst = 1'b1;
    #1;
    check("c_async_rst", {c_grant, c_idx, c_valid, c_tmo}, {3'b000, 2'd0, 1'b0, 1'b0});
    #1;
    c_rst = 1'b0;
    c_req = 3'b111;
    step();
    check("c_ptr_reset", {c_grant, c_idx, c_valid, c_tmo}, {3'b001, 2'd0, 1'b1, 1'b0});
    c_done = 1'b1;
    c_req  = 3'b000;
    step();
    check("c_release", {c_grant, c_idx, c_valid, c_tmo}, {3'b000, 2'd0, 1'b0, 1'b0});
    step();
    check("c_done_idle", {c_grant, c_idx, c_valid, c_tmo}, {3'b000, 2'd0, 1'b0, 1'b0});
    c_done = 1'b0;
    c_req  = 3'b111;
    step();
    check("c_rot1", {c_grant, c_idx, c_valid, c_tmo}, {3'b010, 2'd1, 1'b1, 1'b0});
    c_done = 1'b1;
    step();
    c_done = 1'b0;
    step();
    check("c_rot2", {c_grant, c_idx, c_valid, c_tmo}, {3'b100, 2'd2, 1'b1, 1'b0});
    c_done = 1'b1;
    step();
    c_done = 1'b0;
    step();
    check("c_wrap", {c_grant, c_idx, c_valid, c_tmo}, {3'b001, 2'd0, 1'b1, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
